load_store_unit: RTL

Data-side load/store unit between the core's execute stage and the data memory bus. It consumes the `{funct3, write}` memory control word produced by the main decoder (`mem_w`), the ALU-computed address and the rs2 store data. It runs one aligned byte/half/word bus transaction per request with a req/gnt/rvalid handshake. It returns sign- or zero-extended load data, stalls the core while a transaction is in flight, and flags misaligned, illegal and timed-out accesses.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- types and constants shared between the main decoder and the
// data-side load/store unit.
//   mem_size_e      : funct3 encoding of the access size / extension.
//   LD_OPCODE/ST_OPCODE : major opcodes of loads and stores.
//   mem_legal()     : funct3/write combination is a defined access.
//   mem_misaligned(): address is not naturally aligned for the size.
package riscv_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_e;

    localparam logic [6:0] LD_OPCODE = 7'b0000011;
    localparam logic [6:0] ST_OPCODE = 7'b0100011;

    // Unsigned sizes only exist for loads.
    function automatic logic mem_legal(input logic [2:0] f3, input logic write);
        case (f3)
            MEM_B, MEM_H, MEM_W: return 1'b1;
            MEM_BU, MEM_HU:      return !write;
            default:             return 1'b0;
        endcase
    endfunction

    // f3[1:0] carries the size for both signed and unsigned variants.
    function automatic logic mem_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational data alignment for the load/store unit.
//   size      : access size/extension (funct3)
//   addr_lo   : byte offset within the word
//   wdata     : raw store data (rs2)
//   bus_rdata : raw word from the data bus
//   be        : byte enables for the bus
//   bus_wdata : store data replicated into every lane it may land in
//   load_data : load result shifted to bit 0 and sign/zero extended
module lsu_align
    import riscv_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be        = 4'b1111;
        bus_wdata = wdata;
        shifted   = bus_rdata >> {addr_lo, 3'b000};
        load_data = shifted;

        case (size)
            MEM_B, MEM_BU: begin
                be        = 4'b0001 << addr_lo;
                bus_wdata = {4{wdata[7:0]}};
            end
            MEM_H, MEM_HU: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                bus_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase

        case (size)
            MEM_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_BU:  load_data = {24'h0, shifted[7:0]};
            MEM_HU:  load_data = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- data-side LSU between execute and the data bus.
// One aligned byte/half/word transaction per accepted request over a
// req/gnt/rvalid bus; misaligned, illegal and timed-out accesses are flagged.
//   clk, rst           : clock, async active-high reset
//   lsu_valid/ready    : request handshake from execute (ready only in IDLE)
//   mem_w              : {funct3, write} from the main decoder
//   addr, wdata        : byte address and store data
//   stall              : high while a transaction is in flight
//   lsu_done, err_*    : registered one-cycle completion / error pulses
//   rdata              : extended load data, holds until the next load
//   bus_*              : data bus master side
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic [3:0]  mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_ready,
    output logic        stall,
    output logic        lsu_done,
    output logic [31:0] rdata,
    output logic        err_misalign,
    output logic        err_illegal,
    output logic        err_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e      state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0] addr_q, wdata_q;
    mem_size_e   size_q;
    logic        we_q;

    logic        accept, last_cyc, capture;
    logic        done_n, mis_n, ill_n, to_n;
    logic [3:0]  be;
    logic [31:0] wdata_rep, load_data;

    assign accept    = lsu_valid && (state == IDLE);
    // Leaving on this cycle makes bus_req high for exactly TIMEOUT_CYC cycles.
    assign last_cyc  = (cnt == CW'(TIMEOUT_CYC - 1));
    assign lsu_ready = (state == IDLE);
    assign stall     = (state != IDLE);

    lsu_align u_align (
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .bus_rdata (bus_rdata),
        .be        (be),
        .bus_wdata (wdata_rep),
        .load_data (load_data)
    );

    // Bus fields are only meaningful while requesting; zero otherwise so
    // they idle (and reset) at 0. bus_req falls with the async state reset.
    assign bus_req   = (state == REQ);
    assign bus_we    = bus_req && we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be    = bus_req ? be : 4'h0;
    assign bus_wdata = bus_req ? wdata_rep : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        mis_n   = 1'b0;
        ill_n   = 1'b0;
        to_n    = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!mem_legal(mem_w[3:1], mem_w[0])) begin
                        done_n = 1'b1;
                        ill_n  = 1'b1;
                    end else if (mem_misaligned(mem_w[3:1], addr[1:0])) begin
                        done_n = 1'b1;
                        mis_n  = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                // A completing grant wins over a coincident timeout.
                if (bus_gnt && (we_q || bus_rvalid)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    capture = !we_q;
                end else if (last_cyc) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    to_n    = 1'b1;
                end else if (bus_gnt) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (bus_rvalid) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    capture = 1'b1;
                end else if (last_cyc) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    to_n    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            size_q       <= MEM_B;
            we_q         <= 1'b0;
            lsu_done     <= 1'b0;
            err_misalign <= 1'b0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
            rdata        <= 32'h0;
        end else begin
            lsu_done     <= done_n;
            err_misalign <= mis_n;
            err_illegal  <= ill_n;
            err_timeout  <= to_n;
            if (accept) begin
                cnt     <= '0;
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= mem_size_e'(mem_w[3:1]);
                we_q    <= mem_w[0];
            end else if (state != IDLE) begin
                cnt <= cnt + CW'(1);
            end
            if (capture) rdata <= load_data;
        end
    end

endmodule
